// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator side of the unified scalar/vector data-memory port.
// Latency (RD_LAT=1): aligned store 2, split store 3, aligned load 3, split load 5 cycles from accept.
// Backpressure: req_ready only in IDLE; requests elsewhere are ignored; the response pulse never stalls.
module mem_access_unit #(
  parameter int N      = 32,
  parameter int V      = 256,
  parameter int AW     = 14,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  input  logic           req_write,
  input  logic           req_vector,
  input  logic [N-1:0]   req_addr,
  input  logic [V-1:0]   req_wdata,
  output logic           req_ready,
  output logic           resp_valid,
  output logic [V-1:0]   resp_rdata,
  output logic [AW-1:0]  mem_address,
  output logic [V/8-1:0] mem_byteena,
  output logic [V-1:0]   mem_write_data,
  output logic           mem_rden,
  output logic           mem_wren,
  input  logic [V-1:0]   mem_read_data
);

  localparam int NB = V / 8;                              // byte lanes per line
  localparam int SB = N / 8;                              // byte lanes per scalar
  localparam int OW = $clog2(NB);                         // lane offset width
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;  // wait counter width

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE0 = 3'd1,
    WAIT0  = 3'd2,
    ISSUE1 = 3'd3,
    WAIT1  = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            write_q, write_d;
  logic            vector_q, vector_d;
  logic [OW-1:0]   off_q, off_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [V-1:0]    wdata_q, wdata_d;
  logic [V-1:0]    buf0_q, buf0_d;
  logic [V-1:0]    buf1_q, buf1_d;
  logic [V-1:0]    rdata_q, rdata_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;

  logic            accept;
  logic            split;
  logic [OW-1:0]   req_off;
  logic [V-1:0]    gathered;

  // Address bits above the line index never reach the memory.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[N-1:OW+AW];

  // Byte k of the request lands in lane (o+k) mod NB.
  function automatic logic [V-1:0] rotl_bytes(input logic [V-1:0] d, input logic [OW-1:0] o);
    logic [V-1:0]  r;
    logic [OW-1:0] lane;
    r = '0;
    for (int k = 0; k < NB; k++) begin
      lane = o + OW'(k);
      r[8*lane +: 8] = d[8*k +: 8];
    end
    return r;
  endfunction

  // Byte k of the result comes from lane (o+k) of beat 0, or of beat 1 once it passes the line end.
  function automatic logic [V-1:0] gather_bytes(input logic [V-1:0] b0, input logic [V-1:0] b1,
                                                input logic [OW-1:0] o);
    logic [V-1:0] r;
    logic [OW:0]  idx;
    r = '0;
    for (int k = 0; k < NB; k++) begin
      idx = {1'b0, o} + (OW+1)'(k);
      if (idx[OW]) r[8*k +: 8] = b1[8*idx[OW-1:0] +: 8];
      else         r[8*k +: 8] = b0[8*idx[OW-1:0] +: 8];
    end
    return r;
  endfunction

  assign accept  = req_valid && (state_q == IDLE);
  assign split   = vector_q && (off_q != '0);
  // Scalars are forced onto a scalar-aligned offset so they never cross a line.
  assign req_off = req_vector ? req_addr[OW-1:0]
                              : (req_addr[OW-1:0] & ~OW'(SB - 1));

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      vector_q <= 1'b0;
      off_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      buf0_q   <= '0;
      buf1_q   <= '0;
      rdata_q  <= '0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      vector_q <= vector_d;
      off_q    <= off_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      buf0_q   <= buf0_d;
      buf1_q   <= buf1_d;
      rdata_q  <= rdata_d;
      wcnt_q   <= wcnt_d;
    end
  end

  // Next-state sequencing: one ISSUE cycle per beat, RD_LAT WAIT cycles per load beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE0;
      ISSUE0:  begin
        if (!write_q)   state_d = WAIT0;
        else if (split) state_d = ISSUE1;
        else            state_d = RESP;
      end
      WAIT0:   begin
        if (wcnt_q == '0) state_d = split ? ISSUE1 : RESP;
      end
      ISSUE1:  state_d = write_q ? RESP : WAIT1;
      WAIT1:   if (wcnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, beat address advance, wait counter, line buffers and result assembly.
  always_comb begin
    write_d  = write_q;
    vector_d = vector_q;
    off_d    = off_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    buf0_d   = buf0_q;
    buf1_d   = buf1_q;
    rdata_d  = rdata_q;
    wcnt_d   = wcnt_q;
    gathered = '0;

    if (accept) begin
      write_d  = req_write;
      vector_d = req_vector;
      off_d    = req_off;
      addr_d   = req_addr[OW+AW-1:OW];
      wdata_d  = rotl_bytes(req_vector ? req_wdata : {{(V-N){1'b0}}, req_wdata[N-1:0]}, req_off);
    end

    // Second beat targets the next line; the AW-bit add wraps the last line to 0.
    if (state_d == ISSUE1 && state_q != ISSUE1) addr_d = addr_q + AW'(1);

    if ((state_q == ISSUE0 && state_d == WAIT0) || (state_q == ISSUE1 && state_d == WAIT1)) begin
      wcnt_d = CW'(RD_LAT - 1);
    end else if ((state_q == WAIT0 || state_q == WAIT1) && wcnt_q != '0) begin
      wcnt_d = wcnt_q - CW'(1);
    end

    if (state_q == WAIT0 && wcnt_q == '0) buf0_d = mem_read_data;
    if (state_q == WAIT1 && wcnt_q == '0) buf1_d = mem_read_data;

    // Result is built from the next-cycle buffers so it is valid alongside resp_valid.
    gathered = gather_bytes(buf0_d, buf1_d, off_q);
    if (state_d == RESP && !write_q) begin
      rdata_d = vector_q ? gathered : {{(V-N){1'b0}}, gathered[N-1:0]};
    end
  end

  // Output decode: strobes and byte enables only in ISSUE states.
  always_comb begin
    req_ready   = (state_q == IDLE);
    resp_valid  = (state_q == RESP);
    mem_rden    = 1'b0;
    mem_wren    = 1'b0;
    mem_byteena = '0;
    case (state_q)
      ISSUE0: begin
        mem_rden    = ~write_q;
        mem_wren    = write_q;
        mem_byteena = vector_q ? ({NB{1'b1}} << off_q)
                               : ({{(NB-SB){1'b0}}, {SB{1'b1}}} << off_q);
      end
      ISSUE1: begin
        mem_rden    = ~write_q;
        mem_wren    = write_q;
        mem_byteena = ~({NB{1'b1}} << off_q);
      end
      default: ;
    endcase
  end

  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign resp_rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-enabled, one-cycle-read memory model.
module tb_mem_access_unit;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_write = 1'b0;
  logic         req_vector = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [255:0] req_wdata = '0;
  logic         req_ready;
  logic         resp_valid;
  logic [255:0] resp_rdata;
  logic [13:0]  mem_address;
  logic [31:0]  mem_byteena;
  logic [255:0] mem_write_data;
  logic         mem_rden;
  logic         mem_wren;
  logic [255:0] mem_read_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.N(32), .V(256), .AW(14), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_vector(req_vector),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_address(mem_address), .mem_byteena(mem_byteena),
    .mem_write_data(mem_write_data), .mem_rden(mem_rden), .mem_wren(mem_wren),
    .mem_read_data(mem_read_data)
  );

  // Memory model: byte-lane writes, read data valid only in the cycle after rden.
  logic [255:0] mem_m [0:16383] = '{default: '0};
  logic [255:0] rd_q = '0;
  logic         rd_vld_q = 1'b0;
  logic         mem_init = 1'b0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int j = 0; j < 32; j++) begin
        mem_m[14'h3FFF][8*j +: 8] <= 8'(8'h80 + j);
        mem_m[14'h0000][8*j +: 8] <= 8'(8'hC0 + j);
      end
    end else if (mem_wren) begin
      for (int j = 0; j < 32; j++)
        if (mem_byteena[j]) mem_m[mem_address][8*j +: 8] <= mem_write_data[8*j +: 8];
    end
    rd_vld_q <= mem_rden;
    if (mem_rden) rd_q <= mem_m[mem_address];
  end

  assign mem_read_data = rd_vld_q ? rd_q : {8{32'hDEADBEEF}};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic vec, input logic [31:0] a, input logic [255:0] d);
    req_valid  = 1'b1;
    req_write  = w;
    req_vector = vec;
    req_addr   = a;
    req_wdata  = d;
    step();
    req_valid  = 1'b0;
  endtask

  logic [255:0] w1, w3, w3_rot, exp4;
  int           n;
  logic         bad;

  initial begin
    for (int k = 0; k < 32; k++) begin
      w1[8*k +: 8]             = 8'(k);
      w3[8*k +: 8]             = 8'(8'h40 + k);
      w3_rot[8*((3+k)%32) +: 8] = 8'(8'h40 + k);
      exp4[8*k +: 8]           = (k < 31) ? 8'(8'h81 + k) : 8'hC0;
    end

    // Reset
    #2 rst = 1'b1;
    mem_init = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_strobes", {mem_rden, mem_wren}, 0);
    chk("rst_byteena", mem_byteena, 0);
    chk("rst_addr_wdata", {mem_address, mem_write_data[31:0]}, 0);
    chk("rst_rdata", resp_rdata, 0);
    mem_init = 1'b0;
    rst = 1'b0;
    step();

    // 1: aligned vector store at 0x40
    issue(1'b1, 1'b1, 32'h40, w1);
    chk("t1_c1_strobes", {mem_wren, mem_rden, req_ready, resp_valid}, 4'b1000);
    chk("t1_c1_addr", mem_address, 14'd2);
    chk("t1_c1_byteena", mem_byteena, 32'hFFFF_FFFF);
    chk("t1_c1_wdata", mem_write_data, w1);
    step();
    chk("t1_c2_resp", {resp_valid, mem_wren, mem_byteena}, {2'b10, 32'h0});
    step();
    chk("t1_c3_idle", {resp_valid, req_ready}, 2'b01);

    // 2: scalar load at 0x4E, offset forced to 12
    issue(1'b0, 1'b0, 32'h4E, '0);
    chk("t2_c1_strobes", {mem_rden, mem_wren}, 2'b10);
    chk("t2_c1_addr", mem_address, 14'd2);
    chk("t2_c1_byteena", mem_byteena, 32'h0000_F000);
    step();
    chk("t2_c2_wait", {mem_rden, resp_valid}, 2'b00);
    step();
    chk("t2_c3_resp_valid", resp_valid, 1);
    chk("t2_c3_rdata", resp_rdata, {224'h0, 32'h0F0E0D0C});
    step();

    // 3: split vector store at 0x23, then vector load back
    issue(1'b1, 1'b1, 32'h23, w3);
    chk("t3_b0_addr_en", {mem_wren, mem_address, mem_byteena}, {1'b1, 14'd1, 32'hFFFF_FFF8});
    chk("t3_b0_lane3", mem_write_data[31:24], 8'h40);
    chk("t3_b0_lane0", mem_write_data[7:0], 8'h5D);
    chk("t3_b0_wdata", mem_write_data, w3_rot);
    step();
    chk("t3_b1_addr_en", {mem_wren, mem_address, mem_byteena}, {1'b1, 14'd2, 32'h0000_0007});
    chk("t3_b1_wdata", mem_write_data, w3_rot);
    step();
    chk("t3_c3_resp", {resp_valid, mem_wren}, 2'b10);
    chk("t3_rdata_held", resp_rdata, {224'h0, 32'h0F0E0D0C});
    step();
    issue(1'b0, 1'b1, 32'h23, '0);
    chk("t3l_b0", {mem_rden, mem_address, mem_byteena}, {1'b1, 14'd1, 32'hFFFF_FFF8});
    step();
    chk("t3l_w0", {mem_rden, resp_valid}, 2'b00);
    step();
    chk("t3l_b1", {mem_rden, mem_address, mem_byteena}, {1'b1, 14'd2, 32'h0000_0007});
    step();
    chk("t3l_w1", {mem_rden, resp_valid}, 2'b00);
    step();
    chk("t3l_c5_resp", resp_valid, 1);
    chk("t3l_c5_rdata", resp_rdata, w3);
    step();

    // 4: line wrap, vector load at 0x7FFE1 (L=0x3FFF, o=1)
    issue(1'b0, 1'b1, 32'h0007_FFE1, '0);
    chk("t4_b0", {mem_rden, mem_address, mem_byteena}, {1'b1, 14'h3FFF, 32'hFFFF_FFFE});
    step();
    step();
    chk("t4_b1", {mem_rden, mem_address, mem_byteena}, {1'b1, 14'h0000, 32'h0000_0001});
    step();
    step();
    chk("t4_resp_valid", resp_valid, 1);
    chk("t4_rdata_ends", {resp_rdata[255:240], resp_rdata[7:0]}, 24'hC09F81);
    chk("t4_rdata", resp_rdata, exp4);
    step();

    // 5: reset during WAIT0 of a split load
    issue(1'b0, 1'b1, 32'h23, '0);
    step();
    rst = 1'b1;
    #1;
    chk("t5_strobes", {mem_rden, mem_wren, mem_byteena}, 0);
    chk("t5_ready_resp", {req_ready, resp_valid}, 2'b10);
    chk("t5_rdata", resp_rdata, 0);
    step();
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (resp_valid || mem_rden || mem_wren || !req_ready) bad = 1'b1;
    end
    chk("t5_no_activity", bad, 0);

    // 6: req_valid held with a new address during a busy load
    req_valid = 1'b1; req_write = 1'b0; req_vector = 1'b1; req_addr = 32'h40;
    step();
    req_addr = 32'h23;
    chk("t6_c1", {mem_rden, mem_address}, {1'b1, 14'd2});
    step();
    chk("t6_c2", {mem_rden, req_ready, mem_address}, {2'b00, 14'd2});
    step();
    chk("t6_c3", {resp_valid, req_ready, mem_rden}, 3'b100);
    chk("t6_c3_rdata", resp_rdata[31:0], 32'h035F5E5D);
    step();
    chk("t6_c4_idle", {req_ready, mem_rden, resp_valid, mem_address}, {3'b100, 14'd2});
    step();
    req_valid = 1'b0;
    chk("t6_c5_next", {mem_rden, mem_address, mem_byteena}, {1'b1, 14'd1, 32'hFFFF_FFF8});
    n = 0;
    while (!resp_valid && n < 10) begin
      step();
      n++;
    end
    chk("t6_next_latency", n, 4);
    chk("t6_next_rdata", resp_rdata, w3);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
